alu_control_pipe: RTL

Registered, handshaked successor to the combinational ALU control decoder. It accepts {ALUop, funct} from the decode stage and presents a registered ALU selector to the execute stage over a valid/ready handshake. It adds multi-cycle op support (MULT/DIV) with a parametrised busy counter, flags illegal encodings, and provides a pipeline flush.

---
 rtl/alu_ctrl_pkg.sv | 44 ++++
 rtl/alu_ctrl_decode.sv | 80 ++++++++
 rtl/alu_control_pipe.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared encodings for the ALU control path: ALUop codes, the
//               R-type funct values that are decoded, the ALU selector
//               values and the state encoding of the registered wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    // ALUop field from the main decoder
    localparam logic [1:0] ALUOP_MEM    = 2'b00;  // load/store address add
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;  // branch compare subtract
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;  // decode funct
    localparam logic [1:0] ALUOP_RSVD   = 2'b11;  // reserved, always illegal

    // R-type funct codes (6-bit base encoding, zero-extended by users)
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;

    // ALU selector codes (4-bit base encoding; SEL_ILL is all-ones at any width)
    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;
    localparam logic [3:0] SEL_MUL = 4'b1000;
    localparam logic [3:0] SEL_DIV = 4'b1001;
    localparam logic [3:0] SEL_ILL = 4'b1111;

    // Registered wrapper states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage : alu_ctrl_pkg
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_decode
// Description : Purely combinational ALU control decoder. Maps {aluop, funct}
//               to an ALU selector and flags multi-cycle and illegal ops.
//               Usable on its own by a single-cycle datapath.
// Ports       : aluop   in  2        ALUop from main decoder
//               funct   in  FUNCT_W  R-type funct field (used for aluop 10)
//               sel     out SEL_W    ALU selector
//               multi   out 1        op is MULT or DIV
//               illegal out 1        undefined encoding (sel is all-ones)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W = 6,
    parameter int SEL_W   = 4
) (
    input  logic [1:0]         aluop,
    input  logic [FUNCT_W-1:0] funct,
    output logic [SEL_W-1:0]   sel,
    output logic               multi,
    output logic               illegal
);

    // Size-cast constants so the compare covers every funct bit; any set bit
    // above the base 6-bit encoding makes the op illegal.
    localparam logic [FUNCT_W-1:0] c_FN_ADD  = FUNCT_W'(FN_ADD);
    localparam logic [FUNCT_W-1:0] c_FN_SUB  = FUNCT_W'(FN_SUB);
    localparam logic [FUNCT_W-1:0] c_FN_AND  = FUNCT_W'(FN_AND);
    localparam logic [FUNCT_W-1:0] c_FN_OR   = FUNCT_W'(FN_OR);
    localparam logic [FUNCT_W-1:0] c_FN_SLT  = FUNCT_W'(FN_SLT);
    localparam logic [FUNCT_W-1:0] c_FN_MULT = FUNCT_W'(FN_MULT);
    localparam logic [FUNCT_W-1:0] c_FN_DIV  = FUNCT_W'(FN_DIV);

    always_comb begin
        sel     = '1;
        multi   = 1'b0;
        illegal = 1'b1;
        case (aluop)
            ALUOP_MEM: begin
                sel     = SEL_W'(SEL_ADD);
                illegal = 1'b0;
            end
            ALUOP_BRANCH: begin
                sel     = SEL_W'(SEL_SUB);
                illegal = 1'b0;
            end
            ALUOP_RTYPE: begin
                illegal = 1'b0;
                case (funct)
                    c_FN_ADD:  sel = SEL_W'(SEL_ADD);
                    c_FN_SUB:  sel = SEL_W'(SEL_SUB);
                    c_FN_AND:  sel = SEL_W'(SEL_AND);
                    c_FN_OR:   sel = SEL_W'(SEL_OR);
                    c_FN_SLT:  sel = SEL_W'(SEL_SLT);
                    c_FN_MULT: begin
                        sel   = SEL_W'(SEL_MUL);
                        multi = 1'b1;
                    end
                    c_FN_DIV: begin
                        sel   = SEL_W'(SEL_DIV);
                        multi = 1'b1;
                    end
                    default: begin
                        sel     = '1;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                sel     = '1;
                illegal = 1'b1;
            end
        endcase
    end

endmodule : alu_ctrl_decode
`default_nettype wire

// File: rtl/alu_control_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_control_pipe
// Description : Registered, valid/ready handshaked ALU control stage. Decodes
//               {aluop, funct}, holds the result for the execute stage, and
//               stalls MULT/DIV for MULTI_CYCLES cycles before presenting them.
// Ports       : clk, rst             clock, synchronous active-high reset
//               flush                drop any held or in-flight op
//               in_valid / in_ready  decode-side handshake
//               aluop, funct         op to decode
//               out_valid/out_ready  execute-side handshake
//               sel, multi, illegal  registered decode result
//               busy                 multi-cycle countdown in progress
// Revision    : 1.0 - initial release
// ============================================================================
module alu_control_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W      = 6,
    parameter int SEL_W        = 4,
    parameter int MULTI_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         aluop,
    input  logic [FUNCT_W-1:0] funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   sel,
    output logic               multi,
    output logic               illegal,
    output logic               busy
);

    localparam int                 c_CNT_W    = $clog2(MULTI_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MULTI_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    // With a single execute cycle a multi op needs no countdown at all.
    localparam bit                 c_HAS_WAIT = (MULTI_CYCLES > 1);

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [SEL_W-1:0]     r_sel;
    logic                 r_multi;
    logic                 r_illegal;
    logic                 r_out_valid;
    logic                 r_busy;

    logic [SEL_W-1:0]     w_sel;
    logic                 w_multi;
    logic                 w_illegal;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_drain;

    alu_ctrl_decode #(
        .FUNCT_W (FUNCT_W),
        .SEL_W   (SEL_W)
    ) u_decode (
        .aluop   (aluop),
        .funct   (funct),
        .sel     (w_sel),
        .multi   (w_multi),
        .illegal (w_illegal)
    );

    // HOLD accepts only when the held op drains in the same cycle, so the
    // register is never overwritten with an unconsumed result.
    assign w_in_ready = !rst && !flush &&
                        ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready));
    assign w_accept   = in_valid && w_in_ready;
    assign w_drain    = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_sel       <= '0;
            r_multi     <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HOLD: begin
                    if (w_accept) begin
                        r_sel     <= w_sel;
                        r_multi   <= w_multi;
                        r_illegal <= w_illegal;
                        if (w_multi && c_HAS_WAIT) begin
                            r_state     <= ST_WAIT;
                            r_cnt       <= c_CNT_LOAD;
                            r_busy      <= 1'b1;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_state     <= ST_HOLD;
                            r_cnt       <= '0;
                            r_busy      <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end else if (w_drain) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // The <= compare also keeps the counter from wrapping.
                    if (r_cnt <= c_CNT_ONE) begin
                        r_state     <= ST_HOLD;
                        r_cnt       <= '0;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign sel       = r_sel;
    assign multi     = r_multi;
    assign illegal   = r_illegal;
    assign busy      = r_busy;

endmodule : alu_control_pipe
`default_nettype wire
